data_mem_clr: RTL

- Parametrised successor to the single-port data memory. Configurable data width and depth; depth is decoupled from address width.
- Built-in hardware clear engine zeroes the array after reset and on request, so the CPU never reads uninitialised data.
- Out-of-range writes are detected and flagged.
- Sits on the CPU data path: ALU result drives addr/d_in, register file load path consumes d_out.

---
 rtl/data_mem_pkg.sv | 8 +
 rtl/data_mem_array.sv | 18 +
 rtl/data_mem_clr.sv | 81 ++++++++
 3 files changed

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared state encoding, pointer sizing and clear value for data_mem_clr
package data_mem_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, CLEAR = 2'b01} state_t;
  localparam logic CLR_BIT = 1'b0;
  function automatic int ptr_w(input int addr_w);
    return addr_w + 1;
  endfunction
endpackage

// File: rtl/data_mem_array.sv
// data_mem_array: plain storage, one synchronous write port and one asynchronous read port
module data_mem_array #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  parameter int AW = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [AW-1:0]    ra,
  output logic [WIDTH-1:0] rd
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  assign rd = mem[ra];
endmodule

// File: rtl/data_mem_clr.sv
// data_mem_clr: data memory with hardware clear engine and out-of-range write flag
// Define DATA_MEM_RDREG_EN for a registered (read-first, 1-cycle latency) d_out.
module data_mem_clr import data_mem_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH = 256,
  parameter logic [WIDTH-1:0] CLR_VAL = {WIDTH{CLR_BIT}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  d_in,
  output logic [WIDTH-1:0]  d_out,
  input  logic              clr,
  output logic              busy,
  output logic              err
);
  localparam int PW = ptr_w(ADDR_W);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  if (DEPTH < 2 || DEPTH > 2 ** ADDR_W) begin : g_bad_depth
    $error("data_mem_clr: DEPTH must lie in 2..2**ADDR_W");
  end
  state_t state;
  logic [PW-1:0] clr_ptr;
  logic in_rng, idle_wr, we;
  logic [AW-1:0] wa;
  logic [WIDTH-1:0] wd, rd, rd_v;
  assign in_rng = {1'b0, addr} < DEPTH_P;
  assign idle_wr = (state == IDLE) && en && !clr;
  assign we = (state == CLEAR) || (idle_wr && in_rng);
  assign wa = (state == CLEAR) ? clr_ptr[AW-1:0] : addr[AW-1:0];
  assign wd = (state == CLEAR) ? CLR_VAL : d_in;
  assign rd_v = (busy || !in_rng) ? CLR_VAL : rd;
  data_mem_array #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_array (
    .clk(clk),
    .we(we),
    .wa(wa),
    .wd(wd),
    .ra(addr[AW-1:0]),
    .rd(rd)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      clr_ptr <= '0;
      busy <= 1'b1;
      err <= 1'b0;
    end else begin
      err <= idle_wr && !in_rng;
      case (state)
        IDLE:
          if (clr) begin
            state <= CLEAR;
            clr_ptr <= '0;
            busy <= 1'b1;
          end
        CLEAR:
          if (clr) clr_ptr <= '0;
          else if (clr_ptr == LAST) begin
            state <= IDLE;
            busy <= 1'b0;
          end else clr_ptr <= clr_ptr + 1'b1;
        default: begin
          state <= CLEAR;
          clr_ptr <= '0;
          busy <= 1'b1;
        end
      endcase
    end
  end
`ifdef DATA_MEM_RDREG_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) d_out <= CLR_VAL;
    else d_out <= rd_v;
`else
  assign d_out = rd_v;
`endif
endmodule
